// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
//   sadd_state_t : controller FSM state (IDLE, RUN, DONE)
//   cnt_width()  : width of the bit-slot counter for a given operand width
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sadd_state_t;

   // At least one bit so WIDTH=1 still has a legal counter.
   function automatic int cnt_width(input int w);
      return (w <= 1) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder cell shared by every bit slot of the serial adder.
//   augend, addend, carry_in : operand bits and incoming carry
//   sum, carry_out           : sum bit and outgoing carry
module full_adder (
   input  logic augend,
   input  logic addend,
   input  logic carry_in,
   output logic sum,
   output logic carry_out
);

   logic half_sum;

   assign half_sum  = augend ^ addend;
   assign sum       = half_sum ^ carry_in;
   assign carry_out = (augend & addend) | (carry_in & half_sum);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller: runs one full_adder cell over WIDTH-bit operands, LSB first,
// keeping the carry in a flop between bit slots.
//   clock, reset              : clock and synchronous active-high reset
//   start_valid/start_ready   : operand handshake; augend/addend/carry_in sampled on accept
//   result_valid/result_ready : result handshake; sum/carry_out/overflow held until taken
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] augend,
   input  logic [WIDTH-1:0] addend,
   input  logic             carry_in,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   import serial_add_pkg::*;

   localparam int unsigned CntW = cnt_width(WIDTH);
   localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

   sadd_state_t      state_q, state_d;
   logic [WIDTH-1:0] augend_sh_q, augend_sh_d;
   logic [WIDTH-1:0] addend_sh_q, addend_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic             carry_q, carry_d;
   logic             overflow_q, overflow_d;
   logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;

   logic fa_sum;
   logic fa_carry;

   full_adder u_full_adder (
      .augend    (augend_sh_q[0]),
      .addend    (addend_sh_q[0]),
      .carry_in  (carry_q),
      .sum       (fa_sum),
      .carry_out (fa_carry)
   );

   always_comb begin
      state_d      = state_q;
      augend_sh_d  = augend_sh_q;
      addend_sh_d  = addend_sh_q;
      sum_sh_d     = sum_sh_q;
      carry_d      = carry_q;
      overflow_d   = overflow_q;
      bit_cnt_d    = bit_cnt_q;
      start_ready  = 1'b0;
      result_valid = 1'b0;

      unique case (state_q)
         IDLE: begin
            start_ready = 1'b1;
            if (start_valid) begin
               state_d     = RUN;
               augend_sh_d = augend;
               addend_sh_d = addend;
               carry_d     = carry_in;
               bit_cnt_d   = '0;
               sum_sh_d    = '0;
            end
         end
         RUN: begin
            augend_sh_d           = augend_sh_q >> 1;
            addend_sh_d           = addend_sh_q >> 1;
            sum_sh_d              = sum_sh_q >> 1;
            sum_sh_d[WIDTH-1]     = fa_sum;
            carry_d               = fa_carry;
            if (bit_cnt_q == LastBit) begin
               // carry_q is the carry into the MSB on the last slot.
               overflow_d = carry_q ^ fa_carry;
               state_d    = DONE;
            end else begin
               bit_cnt_d = bit_cnt_q + CntW'(1);
            end
         end
         DONE: begin
            result_valid = 1'b1;
            if (result_ready) begin
               state_d    = IDLE;
               sum_sh_d   = '0;
               carry_d    = 1'b0;
               overflow_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         augend_sh_q <= '0;
         addend_sh_q <= '0;
         sum_sh_q    <= '0;
         carry_q     <= 1'b0;
         overflow_q  <= 1'b0;
         bit_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         augend_sh_q <= augend_sh_d;
         addend_sh_q <= addend_sh_d;
         sum_sh_q    <= sum_sh_d;
         carry_q     <= carry_d;
         overflow_q  <= overflow_d;
         bit_cnt_q   <= bit_cnt_d;
      end
   end

   // In DONE carry_q holds the carry out of bit WIDTH-1; it is zero in IDLE.
   assign sum       = sum_sh_q;
   assign carry_out = carry_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: one instance at WIDTH=8 (index 0) and one at WIDTH=1 (index 1).
module tb_serial_adder_ctrl;

   typedef struct packed {
      logic [7:0] sum;
      logic       co;
      logic       ov;
   } res_t;

   logic       clk;
   logic       rst;
   logic       sv  [2];
   logic       rr  [2];
   logic       cin [2];
   logic [7:0] a   [2];
   logic [7:0] b   [2];
   logic       sr  [2];
   logic       rv  [2];
   logic       co  [2];
   logic       ov  [2];
   logic [7:0] sm  [2];

   logic       sr0, rv0, co0, ov0, sr1, rv1, co1, ov1;
   logic [7:0] sum0;
   logic [0:0] sum1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
      .clock        (clk),
      .reset        (rst),
      .start_valid  (sv[0]),
      .start_ready  (sr0),
      .augend       (a[0]),
      .addend       (b[0]),
      .carry_in     (cin[0]),
      .result_valid (rv0),
      .result_ready (rr[0]),
      .sum          (sum0),
      .carry_out    (co0),
      .overflow     (ov0)
   );

   serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
      .clock        (clk),
      .reset        (rst),
      .start_valid  (sv[1]),
      .start_ready  (sr1),
      .augend       (a[1][0:0]),
      .addend       (b[1][0:0]),
      .carry_in     (cin[1]),
      .result_valid (rv1),
      .result_ready (rr[1]),
      .sum          (sum1),
      .carry_out    (co1),
      .overflow     (ov1)
   );

   assign sr[0] = sr0;
   assign rv[0] = rv0;
   assign co[0] = co0;
   assign ov[0] = ov0;
   assign sm[0] = sum0;
   assign sr[1] = sr1;
   assign rv[1] = rv1;
   assign co[1] = co1;
   assign ov[1] = ov1;
   assign sm[1] = {7'd0, sum1};

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int wid(input int i);
      return (i == 0) ? 8 : 1;
   endfunction

   // Plain integer addition; signed overflow from operand/result signs.
   function automatic res_t model(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                                  input int w);
      logic [8:0] full;
      logic [7:0] mask;
      res_t       r;
      mask  = 8'((9'd1 << w) - 9'd1);
      full  = {1'b0, av & mask} + {1'b0, bv & mask} + {8'd0, cv};
      r.sum = full[7:0] & mask;
      r.co  = full[w];
      r.ov  = (av[w-1] == bv[w-1]) && (r.sum[w-1] != av[w-1]);
      return r;
   endfunction

   task automatic chk(input int i, input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL w%0d %s: got %0h, expected %0h at %0t", wid(i), nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: at most one op in flight, result due WIDTH edges after accept.
   bit   busy [2];
   int   acc  [2];
   res_t ex   [2];

   always @(negedge clk) begin
      #1;
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            logic exp_rv;
            exp_rv = busy[i] && (cyc >= acc[i] + wid(i));
            chk(i, "start_ready", 64'(sr[i]), 64'(!busy[i]));
            chk(i, "result_valid", 64'(rv[i]), 64'(exp_rv));
            if (!busy[i]) begin
               chk(i, "idle_sum", 64'(sm[i]), 64'd0);
               chk(i, "idle_carry", 64'(co[i]), 64'd0);
               chk(i, "idle_ovf", 64'(ov[i]), 64'd0);
            end
            if (exp_rv) begin
               chk(i, "model_sum", 64'(sm[i]), 64'(ex[i].sum));
               chk(i, "model_carry", 64'(co[i]), 64'(ex[i].co));
               chk(i, "model_ovf", 64'(ov[i]), 64'(ex[i].ov));
            end
            if (rst) begin
               busy[i] = 1'b0;
            end else if (exp_rv && rr[i]) begin
               busy[i] = 1'b0;
            end else if (!busy[i] && sv[i]) begin
               busy[i] = 1'b1;
               acc[i]  = cyc + 1;
               ex[i]   = model(a[i], b[i], cin[i], wid(i));
            end
         end
      end
   end

   task automatic wait_ready(input int i);
      int n = 0;
      while (!sr[i] && n < 50) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_valid(input int i, input bit poke);
      int n = 0;
      while (!rv[i] && n < 100) begin
         if (poke) begin
            sv[i] = 1'($urandom_range(0, 1));
            a[i]  = 8'($urandom);
            b[i]  = 8'($urandom);
         end
         @(negedge clk);
         n++;
      end
      sv[i] = 1'b0;
   endtask

   task automatic op(input int i, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                     input int hold, input bit poke,
                     input logic [7:0] es, input logic eco, input logic eov);
      int t0;
      a[i] = av; b[i] = bv; cin[i] = cv; sv[i] = 1'b1; rr[i] = (hold == 0);
      wait_ready(i);
      t0 = cyc + 1;
      @(negedge clk);
      // Scramble operands right after accept; result must not change.
      sv[i] = 1'b0; a[i] = ~av; b[i] = ~bv; cin[i] = ~cv;
      wait_valid(i, poke);
      chk(i, "latency", 64'(cyc - t0), 64'(wid(i)));
      chk(i, "sum", 64'(sm[i]), 64'(es));
      chk(i, "carry_out", 64'(co[i]), 64'(eco));
      chk(i, "overflow", 64'(ov[i]), 64'(eov));
      if (hold > 0) begin
         repeat (hold) begin
            if (poke) begin
               sv[i] = 1'($urandom_range(0, 1));
               a[i]  = 8'($urandom);
            end
            @(negedge clk);
         end
         sv[i] = 1'b0;
         chk(i, "held_valid", 64'(rv[i]), 64'd1);
         chk(i, "held_sum", 64'(sm[i]), 64'(es));
         rr[i] = 1'b1;
      end
      @(negedge clk);
      chk(i, "ready_after", 64'(sr[i]), 64'd1);
      chk(i, "valid_after", 64'(rv[i]), 64'd0);
   endtask

   task automatic b2b(input int i, input logic [7:0] a1, input logic [7:0] b1, input logic c1,
                      input logic [7:0] a2, input logic [7:0] b2, input logic c2,
                      input logic [7:0] es, input logic eco, input logic eov);
      int t1, t2;
      rr[i] = 1'b1; a[i] = a1; b[i] = b1; cin[i] = c1; sv[i] = 1'b1;
      wait_ready(i);
      t1 = cyc + 1;
      @(negedge clk);
      a[i] = a2; b[i] = b2; cin[i] = c2;
      wait_ready(i);
      t2 = cyc + 1;
      chk(i, "b2b_gap", 64'(t2 - t1), 64'(wid(i) + 2));
      @(negedge clk);
      sv[i] = 1'b0;
      wait_valid(i, 1'b0);
      chk(i, "b2b_sum", 64'(sm[i]), 64'(es));
      chk(i, "b2b_carry", 64'(co[i]), 64'(eco));
      chk(i, "b2b_ovf", 64'(ov[i]), 64'(eov));
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         sv[i] = 1'b0; rr[i] = 1'b1; cin[i] = 1'b0; a[i] = '0; b[i] = '0;
         busy[i] = 1'b0; acc[i] = 0; ex[i] = '0;
      end
      @(posedge clk);
      #1 chk_en = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk(i, "rst_ready", 64'(sr[i]), 64'd1);
         chk(i, "rst_valid", 64'(rv[i]), 64'd0);
         chk(i, "rst_sum", 64'(sm[i]), 64'd0);
         chk(i, "rst_carry", 64'(co[i]), 64'd0);
         chk(i, "rst_ovf", 64'(ov[i]), 64'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      op(0, 8'h35, 8'h4A, 1'b0, 0, 1'b0, 8'h7F, 1'b0, 1'b0);
      op(0, 8'hFF, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0);
      op(0, 8'h7F, 8'h01, 1'b0, 0, 1'b0, 8'h80, 1'b0, 1'b1);
      op(0, 8'h80, 8'h80, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b1);
      // Backpressure for 20 cycles with start_valid poked during RUN and DONE.
      op(0, 8'h5A, 8'hC3, 1'b0, 20, 1'b1, 8'h1D, 1'b1, 1'b0);

      // Reset during the 4th RUN cycle.
      a[0] = 8'hAA; b[0] = 8'h55; cin[0] = 1'b0; sv[0] = 1'b1; rr[0] = 1'b1;
      wait_ready(0);
      @(negedge clk);
      sv[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk(0, "rstmid_ready", 64'(sr[0]), 64'd1);
      chk(0, "rstmid_valid", 64'(rv[0]), 64'd0);
      chk(0, "rstmid_sum", 64'(sm[0]), 64'd0);
      op(0, 8'h01, 8'h01, 1'b0, 0, 1'b0, 8'h02, 1'b0, 1'b0);

      b2b(0, 8'h12, 8'h34, 1'b0, 8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0);

      op(1, 8'h01, 8'h01, 1'b1, 0, 1'b0, 8'h01, 1'b1, 1'b0);
      op(1, 8'h00, 8'h00, 1'b1, 3, 1'b1, 8'h01, 1'b0, 1'b1);
      b2b(1, 8'h01, 8'h01, 1'b1, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
